window_scan_controller: RTL
===========================

Name: window_scan_controller

Overview:
- Parametrised successor to the fixed free-running coordinate iterator at the top of the face detection IP.
- Tracks raster coordinates of an accepted pixel stream at a runtime-configured frame size. Detects every position where a full INTEGRAL_LENGTH x INTEGRAL_LENGTH window completes, subject to a configurable stride.
- Queues the window top-left coordinates in a FIFO for the first-phase Haar cascade, using a valid/ready handshake.
- Sits between the camera pixel interface and the I2LBS/cascade front end. Supports stall or drop behaviour when the cascade falls behind.

Parameters:
- DATA_WIDTH_12, 12, coordinate and dimension width.
- INTEGRAL_LENGTH, 8, window side in pixels.
- MAX_FRAME_DIM, 4095, largest legal frame width or height.
- STEP_WIDTH, 4, width of the stride config; stride range is 1..2^STEP_WIDTH-1.
- FIFO_DEPTH, 4, pending-window queue depth; power of two, >=2.
- BACKPRESSURE, 1, selects full-FIFO policy: 1 = stall pixel input, 0 = drop window and count it.

Ports:
- clk_fpga  in  1  system clock
- reset_fpga  in  1  asynchronous, active-low reset
- i_frame_width  in  DATA_WIDTH_12  frame width; sampled on i_start
- i_frame_height  in  DATA_WIDTH_12  frame height; sampled on i_start
- i_step  in  STEP_WIDTH  window stride; sampled on i_start
- i_start  in  1  one-cycle request to begin a frame; honoured only in IDLE
- i_pixel_valid  in  1  pixel present this cycle
- o_pixel_ready  out  1  controller accepts the pixel this cycle
- o_xcoord  out  DATA_WIDTH_12  column of the next pixel to be accepted
- o_ycoord  out  DATA_WIDTH_12  row of the next pixel to be accepted
- o_win_valid  out  1  FIFO non-empty
- i_win_ready  in  1  cascade takes the head entry
- o_win_x  out  DATA_WIDTH_12  window top-left column (FIFO head)
- o_win_y  out  DATA_WIDTH_12  window top-left row (FIFO head)
- o_busy  out  1  state is not IDLE
- o_frame_done  out  1  one-cycle pulse on DRAIN->IDLE
- o_cfg_err  out  1  sticky; set by an illegal config, cleared by the next legal i_start
- o_drop_count  out  16  saturating count of windows dropped in the current frame

Behaviour:
- Reset: all outputs, FIFO pointers and coordinates go to 0; state = IDLE. Assertion mid-frame aborts immediately; no frame_done pulse.
- Accept rule: accept = i_pixel_valid & o_pixel_ready.
- o_pixel_ready = (state==SCAN) & (BACKPRESSURE==0 | !fifo_full). Depends on registered state only; no combinational path from i_win_ready.
- IDLE, on i_start:
  - Latch config.
  - Illegal config: width or height < INTEGRAL_LENGTH or > MAX_FRAME_DIM, or step==0. Set o_cfg_err and stay in IDLE.
  - Legal config: clear o_cfg_err, o_drop_count and coordinates; go to SCAN.
- SCAN, per accepted pixel:
  - x increments; at width-1, x wraps to 0 and y increments.
  - On the last pixel (width-1, height-1), go to DRAIN.
- Window emit condition, at the accepted pixel (x,y), all of:
  - x >= L-1 and y >= L-1;
  - (x-(L-1)) mod step == 0 and (y-(L-1)) mod step == 0.
  - Implement the mod with per-axis phase counters reset at window origin; no divider.
  - Pushed entry = (x-L+1, y-L+1).
- Emit on full FIFO:
  - BACKPRESSURE=1: cannot occur, because input is stalled.
  - BACKPRESSURE=0: entry discarded; o_drop_count += 1, saturating at 0xFFFF.
  - Push and pop in the same cycle on a full FIFO succeed; no drop.
- FIFO:
  - First-word fall-through.
  - Pop on o_win_valid & i_win_ready.
  - A push appears on o_win_valid one cycle after the accepting edge. Latency = 1.
  - o_win_x/o_win_y hold stable while valid & !ready.
- DRAIN: no pixels accepted. When FIFO empty, pulse o_frame_done and go to IDLE. i_start is ignored in SCAN and DRAIN.
- Expected windows per frame = (floor((W-L)/step)+1) * (floor((H-L)/step)+1).

Decomposition:
- Shared package holds: DATA_WIDTH_8/12/16, INTEGRAL_LENGTH default, the state enum (IDLE, SCAN, DRAIN), and the window-entry struct {x,y}.
- One sub-module: window_coord_fifo, a parametrised-depth FWFT FIFO with full/empty and simultaneous push/pop.

Test Plan:
- Continuous valid, W=H=10, L=8, step=1, ready=1 -> 9 windows:
  - first (0,0) appears 1 cycle after pixel (7,7) is accepted;
  - last is (2,2);
  - then one frame_done pulse.
- Same frame with step=2 -> exactly 4 windows: (0,0), (2,0), (0,2), (2,2).
- BACKPRESSURE=1, FIFO_DEPTH=4, i_win_ready=0, W=H=10, step=1:
  - o_pixel_ready drops after the 4th window push, while the accepted pixel is (7,8);
  - releasing ready resumes the frame;
  - all 9 windows are delivered in order.
- BACKPRESSURE=0, same stimulus -> 4 entries held, o_drop_count=5, pixels never stalled, frame_done after the FIFO drains.
- i_start with width=5 or step=0 -> o_cfg_err=1, o_busy=0. A next start with W=10 clears o_cfg_err.
- reset_fpga low at pixel (4,3) -> all outputs 0 asynchronously, no frame_done. A new start produces a correct 9-window frame.

Source files
------------

// File: rtl/window_scan_controller_pkg.sv
// Shared types and constants for the window scan controller and its FIFO.
package window_scan_controller_pkg;

   localparam int DATA_WIDTH_8        = 8;
   localparam int DATA_WIDTH_12       = 12;
   localparam int DATA_WIDTH_16       = 16;
   localparam int INTEGRAL_LENGTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } scan_state_e;

   typedef struct packed {
      logic [DATA_WIDTH_12-1:0] x;
      logic [DATA_WIDTH_12-1:0] y;
   } win_entry_t;

endpackage

// File: rtl/window_scan_controller_if.sv
// Pixel and window handshake bundle between camera side, controller and cascade.
interface window_scan_controller_if import window_scan_controller_pkg::*; #(
   parameter int DW = DATA_WIDTH_12
);
   logic          i_pixel_valid;
   logic          o_pixel_ready;
   logic          o_win_valid;
   logic          i_win_ready;
   logic [DW-1:0] o_win_x;
   logic [DW-1:0] o_win_y;

   modport master (
      output i_pixel_valid, i_win_ready,
      input  o_pixel_ready, o_win_valid, o_win_x, o_win_y
   );

   modport slave (
      input  i_pixel_valid, i_win_ready,
      output o_pixel_ready, o_win_valid, o_win_x, o_win_y
   );
endinterface

// File: rtl/window_coord_fifo.sv
// First-word fall-through FIFO of pending window coordinates.
module window_coord_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 24
) (
   input  logic             clk_fpga,
   input  logic             reset_fpga,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   import window_scan_controller_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // a full FIFO still takes a push when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_q];

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) begin
         mem_d[wr_q] = din;
         wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
         rd_d = rd_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_fpga or negedge reset_fpga) begin
      if (!reset_fpga) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/window_scan_controller.sv
// Raster coordinate tracker that queues top-left corners of completed, stride-aligned windows.
//   state    | meaning
//   ST_IDLE  | waiting for i_start; config checked and latched here
//   ST_SCAN  | accepting pixels, emitting windows into the FIFO
//   ST_DRAIN | frame fully accepted, waiting for the FIFO to empty
module window_scan_controller #(
   parameter int DATA_WIDTH_12   = 12,
   parameter int INTEGRAL_LENGTH = 8,
   parameter int MAX_FRAME_DIM   = 4095,
   parameter int STEP_WIDTH      = 4,
   parameter int FIFO_DEPTH      = 4,
   parameter int BACKPRESSURE    = 1
) (
   input  logic                     clk_fpga,
   input  logic                     reset_fpga,
   input  logic [DATA_WIDTH_12-1:0] i_frame_width,
   input  logic [DATA_WIDTH_12-1:0] i_frame_height,
   input  logic [STEP_WIDTH-1:0]    i_step,
   input  logic                     i_start,
   window_scan_controller_if.slave  bus,
   output logic [DATA_WIDTH_12-1:0] o_xcoord,
   output logic [DATA_WIDTH_12-1:0] o_ycoord,
   output logic                     o_busy,
   output logic                     o_frame_done,
   output logic                     o_cfg_err,
   output logic [15:0]              o_drop_count
);
   import window_scan_controller_pkg::*;

   localparam int            DW   = DATA_WIDTH_12;
   localparam logic [DW-1:0] L_M1 = DW'(INTEGRAL_LENGTH - 1);

   scan_state_e             state_q, state_d;
   logic [DW-1:0]           w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
   logic [STEP_WIDTH-1:0]   step_q, step_d, px_q, px_d, py_q, py_d;
   logic                    cfg_err_q, cfg_err_d, frame_done_q, frame_done_d;
   logic [15:0]             drop_q, drop_d;

   logic                    cfg_legal, accept, win_hit, push, pop;
   logic                    fifo_full, fifo_empty;
   win_entry_t              push_entry, head;

   assign cfg_legal = !((int'(i_frame_width)  < INTEGRAL_LENGTH) ||
                        (int'(i_frame_width)  > MAX_FRAME_DIM)   ||
                        (int'(i_frame_height) < INTEGRAL_LENGTH) ||
                        (int'(i_frame_height) > MAX_FRAME_DIM)   ||
                        (i_step == '0));

   assign bus.o_pixel_ready = (state_q == ST_SCAN) && ((BACKPRESSURE == 0) || !fifo_full);
   assign accept            = bus.i_pixel_valid && bus.o_pixel_ready;
   assign pop               = !fifo_empty && bus.i_win_ready;

   // phase counters sit at zero exactly on stride-aligned window origins
   assign win_hit      = (x_q >= L_M1) && (y_q >= L_M1) && (px_q == '0) && (py_q == '0);
   assign push_entry.x = x_q - L_M1;
   assign push_entry.y = y_q - L_M1;

   always_comb begin
      state_d      = state_q;
      w_d          = w_q;
      h_d          = h_q;
      step_d       = step_q;
      x_d          = x_q;
      y_d          = y_q;
      px_d         = px_q;
      py_d         = py_q;
      cfg_err_d    = cfg_err_q;
      drop_d       = drop_q;
      frame_done_d = 1'b0;
      push         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               w_d    = i_frame_width;
               h_d    = i_frame_height;
               step_d = i_step;
               if (cfg_legal) begin
                  cfg_err_d = 1'b0;
                  drop_d    = '0;
                  x_d       = '0;
                  y_d       = '0;
                  px_d      = '0;
                  py_d      = '0;
                  state_d   = ST_SCAN;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         ST_SCAN: begin
            if (accept) begin
               if (win_hit) begin
                  if (!fifo_full || pop) push = 1'b1;
                  else if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
               end
               if (x_q == w_q - DW'(1)) begin
                  x_d  = '0;
                  px_d = '0;
                  if (y_q == h_q - DW'(1)) begin
                     y_d     = '0;
                     py_d    = '0;
                     state_d = ST_DRAIN;
                  end else begin
                     y_d = y_q + DW'(1);
                     if (y_q >= L_M1)
                        py_d = (py_q == step_q - STEP_WIDTH'(1)) ? '0 : py_q + STEP_WIDTH'(1);
                  end
               end else begin
                  x_d = x_q + DW'(1);
                  if (x_q >= L_M1)
                     px_d = (px_q == step_q - STEP_WIDTH'(1)) ? '0 : px_q + STEP_WIDTH'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) begin
               frame_done_d = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_fpga or negedge reset_fpga) begin
      if (!reset_fpga) begin
         state_q      <= ST_IDLE;
         w_q          <= '0;
         h_q          <= '0;
         step_q       <= '0;
         x_q          <= '0;
         y_q          <= '0;
         px_q         <= '0;
         py_q         <= '0;
         cfg_err_q    <= 1'b0;
         drop_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         w_q          <= w_d;
         h_q          <= h_d;
         step_q       <= step_d;
         x_q          <= x_d;
         y_q          <= y_d;
         px_q         <= px_d;
         py_q         <= py_d;
         cfg_err_q    <= cfg_err_d;
         drop_q       <= drop_d;
         frame_done_q <= frame_done_d;
      end
   end

   window_coord_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(win_entry_t))
   ) u_fifo (
      .clk_fpga   (clk_fpga),
      .reset_fpga (reset_fpga),
      .push       (push),
      .din        (push_entry),
      .pop        (pop),
      .dout       (head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   assign bus.o_win_valid = !fifo_empty;
   assign bus.o_win_x     = head.x;
   assign bus.o_win_y     = head.y;
   assign o_xcoord        = x_q;
   assign o_ycoord        = y_q;
   assign o_busy          = (state_q != ST_IDLE);
   assign o_frame_done    = frame_done_q;
   assign o_cfg_err       = cfg_err_q;
   assign o_drop_count    = drop_q;
endmodule
